// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC control sequencer and the debug/trace unit.
package pc_seq_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_FETCH = 2'd0;
   localparam state_t ST_EXEC  = 2'd1;
   localparam state_t ST_IRQ   = 2'd2;

   // Address the PC register loads when its irq input is strobed.
   localparam int IRQ_VECTOR = 1;

endpackage

// File: rtl/pc_seq_if.sv
// Fetch/execute handshake and PC-control bundle between the core control
// unit (master) and the sequencer (slave).
interface pc_seq_if #(
   parameter int RW = 16
);

   logic [RW-1:0] i_pc;
   logic          i_mem_ack;
   logic          i_stall;
   logic          i_exec_done;
   logic          i_jmp;
   logic          i_iret;
   logic          i_irq;
   logic          i_ie_set;
   logic          i_ie_clr;
   logic          o_c_pc_inc;
   logic          o_c_pc_ie;
   logic          o_c_pc_irq;
   logic          o_fetch_req;
   logic          o_irq_ack;
   logic          o_irq_en;
   logic [RW-1:0] o_epc;
   logic [RW-1:0] o_retired;

   modport master (
      output i_pc, i_mem_ack, i_stall, i_exec_done, i_jmp, i_iret,
             i_irq, i_ie_set, i_ie_clr,
      input  o_c_pc_inc, o_c_pc_ie, o_c_pc_irq, o_fetch_req, o_irq_ack,
             o_irq_en, o_epc, o_retired
   );

   modport slave (
      input  i_pc, i_mem_ack, i_stall, i_exec_done, i_jmp, i_iret,
             i_irq, i_ie_set, i_ie_clr,
      output o_c_pc_inc, o_c_pc_ie, o_c_pc_irq, o_fetch_req, o_irq_ack,
             o_irq_en, o_epc, o_retired
   );

endinterface

// File: rtl/pc_seq_irq_latch.sv
// Interrupt edge detect, pending flag and enable flag.
// Enable priority: entry clear > ie_clr > iret set > ie_set.
module pc_seq_irq_latch (
   input  logic clk_i,
   input  logic rst_i,
   input  logic irq_i,
   input  logic ie_set_i,
   input  logic ie_clr_i,
   input  logic iret_i,
   input  logic entered_i,
   output logic take_irq_o,
   output logic irq_en_o
);

   logic irq_prev_q;
   logic pending_q, pending_d;
   logic en_q, en_d;
   logic en_eff;
   logic rise;

   assign rise = irq_i && !irq_prev_q;

   // Enable as seen at the instruction boundary, and pending next-state.
   // A fresh edge during interrupt entry re-arms pending instead of being lost.
   always_comb begin
      if (ie_clr_i)      en_eff = 1'b0;
      else if (iret_i)   en_eff = 1'b1;
      else if (ie_set_i) en_eff = 1'b1;
      else               en_eff = en_q;

      en_d      = entered_i ? 1'b0 : en_eff;
      pending_d = rise ? 1'b1 : (entered_i ? 1'b0 : pending_q);
   end

   // Flag registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_prev_q <= 1'b0;
         pending_q  <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         irq_prev_q <= irq_i;
         pending_q  <= pending_d;
         en_q       <= en_d;
      end
   end

   assign take_irq_o = pending_q && en_eff;
   assign irq_en_o   = en_q;

endmodule

// File: rtl/pc_seq.sv
// PC control sequencer: fetch/execute/interrupt-entry FSM driving the PC
// register strobes, plus exception PC capture and retired-instruction count.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_FETCH | fetch_req high, waiting for an unstalled mem_ack
//   ST_EXEC  | instruction executing; exec_done strobes inc or ie
//   ST_IRQ   | one-cycle interrupt entry: load vector, save EPC, ack
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int RW = 16
) (
   input logic     i_clk,
   input logic     i_rst,
   pc_seq_if.slave bus
);

   state_t        state_q, state_d;
   logic [RW-1:0] epc_q;
   logic [RW-1:0] retired_q;
   logic          done_w;
   logic          entered_w;
   logic          take_irq;
   logic          irq_en;

   assign done_w    = (state_q == ST_EXEC) && bus.i_exec_done && !i_rst;
   assign entered_w = (state_q == ST_IRQ) && !i_rst;

   pc_seq_irq_latch u_irq_latch (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .irq_i      (bus.i_irq),
      .ie_set_i   (bus.i_ie_set),
      .ie_clr_i   (bus.i_ie_clr),
      .iret_i     (done_w && bus.i_iret),
      .entered_i  (entered_w),
      .take_irq_o (take_irq),
      .irq_en_o   (irq_en)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

   // Next-state logic; interrupts are only taken at instruction boundaries.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: if (bus.i_mem_ack && !bus.i_stall) state_d = ST_EXEC;
         ST_EXEC:  if (bus.i_exec_done) state_d = take_irq ? ST_IRQ : ST_FETCH;
         ST_IRQ:   state_d = ST_FETCH;
         default:  state_d = ST_FETCH;
      endcase
   end

   // Strobes; suppressed during reset so an abandoned state emits nothing.
   always_comb begin
      bus.o_fetch_req = (state_q == ST_FETCH);
      bus.o_c_pc_inc  = done_w && !(bus.i_jmp || bus.i_iret);
      bus.o_c_pc_ie   = done_w && (bus.i_jmp || bus.i_iret);
      bus.o_c_pc_irq  = entered_w;
      bus.o_irq_ack   = entered_w;
   end

   // EPC capture on entry (i_pc already holds the next PC) and retire count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         epc_q     <= '0;
         retired_q <= '0;
      end else begin
         if (state_q == ST_IRQ) epc_q <= bus.i_pc;
         if (done_w) retired_q <= retired_q + RW'(1);
      end
   end

   assign bus.o_irq_en  = irq_en;
   assign bus.o_epc     = epc_q;
   assign bus.o_retired = retired_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: per-cycle vector table routed through an expected-value
// queue, strobe exclusivity every cycle, and a counter-wrap run on a narrow
// instance.
module tb_pc_seq;

   typedef struct packed {
      logic        rst, ack, stl, dn, jmp, iret, irq, set, clr;
      logic [15:0] pc;
   } in_t;

   typedef struct packed {
      logic        fr, inc, ie, iq, ak, en;
      logic [15:0] epc, ret;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   typedef struct {
      int   idx;
      out_t o;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic w_rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   vec_t vecs[$];
   sb_t  exp_q[$];

   always #5 clk = ~clk;

   pc_seq_if #(.RW(16)) m_if ();
   pc_seq_if #(.RW(8))  w_if ();

   pc_seq #(.RW(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (m_if.slave)
   );

   // Narrow instance so the retire counter wrap is reachable quickly.
   pc_seq #(.RW(8)) u_wrap (
      .i_clk (clk),
      .i_rst (w_rst),
      .bus   (w_if.slave)
   );

   task automatic add(input logic r, a, s, d, j, ir, q, st, cl, input logic [15:0] pc,
                      input logic fr, inc, ie, iq, ak, en, input logic [15:0] epc, ret);
      vec_t v;
      v.i = '{rst: r, ack: a, stl: s, dn: d, jmp: j, iret: ir, irq: q, set: st, clr: cl, pc: pc};
      v.o = '{fr: fr, inc: inc, ie: ie, iq: iq, ak: ak, en: en, epc: epc, ret: ret};
      vecs.push_back(v);
   endtask

   task automatic apply(input in_t v);
      rst              = v.rst;
      m_if.i_mem_ack   = v.ack;
      m_if.i_stall     = v.stl;
      m_if.i_exec_done = v.dn;
      m_if.i_jmp       = v.jmp;
      m_if.i_iret      = v.iret;
      m_if.i_irq       = v.irq;
      m_if.i_ie_set    = v.set;
      m_if.i_ie_clr    = v.clr;
      m_if.i_pc        = v.pc;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   // Scoreboard compare and per-cycle strobe exclusivity, away from the edge.
   always @(negedge clk) begin
      sb_t  e;
      out_t act;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = '{fr: m_if.o_fetch_req, inc: m_if.o_c_pc_inc, ie: m_if.o_c_pc_ie,
                 iq: m_if.o_c_pc_irq, ak: m_if.o_irq_ack, en: m_if.o_irq_en,
                 epc: m_if.o_epc, ret: m_if.o_retired};
         n_chk++;
         if (act === e.o) n_pass++;
         else $display("FAIL vec%0d actual fr/inc/ie/irq/ack/en=%b epc=%h ret=%h required %b epc=%h ret=%h",
                       e.idx, act[37:32], act.epc, act.ret, e.o[37:32], e.o.epc, e.o.ret);
      end
      n_chk++;
      if ($countones({m_if.o_c_pc_inc, m_if.o_c_pc_ie, m_if.o_c_pc_irq}) <= 1 &&
          $countones({w_if.o_c_pc_inc, w_if.o_c_pc_ie, w_if.o_c_pc_irq}) <= 1)
         n_pass++;
      else
         $display("FAIL strobe_excl at %0t actual main=%b wrap=%b required at most one high", $time,
                  {m_if.o_c_pc_inc, m_if.o_c_pc_ie, m_if.o_c_pc_irq},
                  {w_if.o_c_pc_inc, w_if.o_c_pc_ie, w_if.o_c_pc_irq});
   end

   initial begin
      //   rst ack stl dn jmp iret irq set clr pc         fr inc ie iq ak en epc      ret
      // straight line, no stall
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0001,   0, 1, 0, 0, 0, 0, 16'h0000, 16'd0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd1);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0002,   0, 1, 0, 0, 0, 0, 16'h0000, 16'd1);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0002,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0003,   0, 1, 0, 0, 0, 0, 16'h0000, 16'd2);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0003,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd3);
      // stalled fetch then branch
      add(0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0003,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd3);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0003,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd3);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0003,   0, 0, 0, 0, 0, 0, 16'h0000, 16'd3);
      add(0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0030,   0, 0, 1, 0, 0, 0, 16'h0000, 16'd3);
      // interrupt entry
      add(0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0030,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd4);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0041,   0, 0, 0, 0, 0, 1, 16'h0000, 16'd4);
      add(0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0041,   0, 1, 0, 0, 0, 1, 16'h0000, 16'd4);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0042,   0, 0, 0, 1, 1, 1, 16'h0000, 16'd5);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h0042, 16'd5);
      // masked interrupt, released by iret
      add(0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h0042, 16'd5);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0002,   0, 1, 0, 0, 0, 0, 16'h0042, 16'd5);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0002,   1, 0, 0, 0, 0, 0, 16'h0042, 16'd6);
      add(0, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0002,   0, 0, 1, 0, 0, 0, 16'h0042, 16'd6);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234,   0, 0, 0, 1, 1, 1, 16'h0042, 16'd7);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h1234, 16'd7);
      // set and clear together: clear wins
      add(0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h1234, 16'd7);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h1234, 16'd7);
      // new edge during the IRQ cycle re-arms pending
      add(0, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h1234, 16'd7);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0002,   0, 1, 0, 0, 0, 1, 16'h1234, 16'd7);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0050,   0, 0, 0, 1, 1, 1, 16'h1234, 16'd8);
      add(0, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h0050, 16'd8);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0002,   0, 1, 0, 0, 0, 1, 16'h0050, 16'd8);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0060,   0, 0, 0, 1, 1, 1, 16'h0050, 16'd9);
      // reset while in EXEC with exec_done
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0001,   1, 0, 0, 0, 0, 0, 16'h0060, 16'd9);
      add(1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0002,   0, 0, 0, 0, 0, 0, 16'h0060, 16'd9);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd0);
      add(0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0000,   1, 0, 0, 0, 0, 0, 16'h0000, 16'd0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0001,   0, 1, 0, 0, 0, 1, 16'h0000, 16'd0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0001,   1, 0, 0, 0, 0, 1, 16'h0000, 16'd1);

      apply('{rst: 1'b1, default: '0});
      w_if.i_pc = '0; w_if.i_mem_ack = 1'b1; w_if.i_stall = 1'b0;
      w_if.i_exec_done = 1'b1; w_if.i_jmp = 1'b0; w_if.i_iret = 1'b0;
      w_if.i_irq = 1'b0; w_if.i_ie_set = 1'b0; w_if.i_ie_clr = 1'b0;
      repeat (2) @(posedge clk);

      for (int k = 0; k < vecs.size(); k++) begin
         @(posedge clk);
         #1;
         apply(vecs[k].i);
         exp_q.push_back('{idx: k, o: vecs[k].o});
      end
      @(posedge clk);
      #1;
      apply('{default: '0});

      // Wrap: back-to-back instructions, one retirement every two cycles.
      @(posedge clk);
      #1 w_rst = 1'b0;
      repeat (510) @(posedge clk);
      #4;
      check("wrap_pre", {8'h00, w_if.o_retired}, 16'h00FF);
      check("wrap_inc", {15'h0, w_if.o_c_pc_inc}, 16'h0000);
      @(posedge clk);
      #4;
      check("wrap_inc_last", {15'h0, w_if.o_c_pc_inc}, 16'h0001);
      @(posedge clk);
      #4;
      check("wrap_post", {8'h00, w_if.o_retired}, 16'h0000);

      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
